// File: rtl/io_serial_pkg.sv
// Shared definitions for the host serial link: frame header tag, channel ids
// and the state encodings of the byte receiver and the frame parser.
package io_serial_pkg;

  localparam logic [4:0] FRAME_HDR_TAG = 5'b10100;
  localparam int         NUM_CHAN      = 6;

  typedef enum logic [2:0] {
    CH_DSKY_VERB = 3'd0,
    CH_DSKY_NOUN = 3'd1,
    CH_AXI_G     = 3'd2,
    CH_AXI_RA    = 3'd3,
    CH_AXI_RB    = 3'd4,
    CH_AXI_ATX   = 3'd5
  } chan_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    PS_HDR = 2'd0,
    PS_HI  = 2'd1,
    PS_LO  = 2'd2
  } parse_state_e;

  // A header byte carries the tag in [7:3] and a channel id 0..5 in [2:0].
  function automatic logic is_header(input logic [7:0] b);
    return (b[7:3] == FRAME_HDR_TAG) && (b[2:0] < 3'd6);
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with a 2-flop input synchronizer.
// byte_valid / byte_err are single-cycle strobes with no backpressure: the
// consumer must take byte_data in the cycle byte_valid is high; byte_err
// marks a byte whose stop bit sampled low and carries no usable data.
module uart_rx_byte
  import io_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_serial,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    sync_q;
  logic          rx;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_d, err_d;

  assign rx        = sync_q[1];
  assign byte_data = shift_q;

  // Two-flop synchronizer; resets to the idle-high line level.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx_serial};
  end

  // State and datapath registers of the receiver.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      byte_valid <= valid_d;
      byte_err   <= err_d;
    end
  end

  // Next-state: start is confirmed at mid-bit, then one sample per bit period.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          // A line that is high again at mid-start was a glitch.
          state_d = rx ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {rx, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          valid_d = rx;
          err_d   = !rx;
          state_d = RX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/io_serial_rx.sv
// Host link receiver: parses 3-byte channel-update frames (header, high
// 7 bits, low 8 bits) and holds the latest 15-bit value for each of the six
// AGC input channels. Outputs are registered and read combinationally by
// the register file.
module io_serial_rx
  import io_serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_CLKS = 65536
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_serial,
  output logic [14:0] dsky_verb,
  output logic [14:0] dsky_noun,
  output logic [14:0] axi_g,
  output logic [14:0] axi_ra,
  output logic [14:0] axi_rb,
  output logic [14:0] axi_atx,
  output logic        update_valid,
  output logic [2:0]  update_chan,
  output logic        frame_err
);

  localparam int            TW        = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CLKS - 1);

  logic [7:0]    byte_data;
  logic          byte_valid, byte_err;

  parse_state_e  state_q, state_d;
  chan_e         chan_q, chan_d;
  logic [6:0]    hi_q, hi_d;
  logic [TW-1:0] idle_q, idle_d;
  logic          load_en, err_d, timeout_hit;
  logic [14:0]   chan_reg [NUM_CHAN];

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clock     (clock),
    .reset     (reset),
    .rx_serial (rx_serial),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_err  (byte_err)
  );

  assign dsky_verb = chan_reg[CH_DSKY_VERB];
  assign dsky_noun = chan_reg[CH_DSKY_NOUN];
  assign axi_g     = chan_reg[CH_AXI_G];
  assign axi_ra    = chan_reg[CH_AXI_RA];
  assign axi_rb    = chan_reg[CH_AXI_RB];
  assign axi_atx   = chan_reg[CH_AXI_ATX];

  // The idle counter hitting its last value aborts a partially received frame.
  assign timeout_hit = (state_q != PS_HDR) && (idle_q == IDLE_LAST);

  // Parser state, latched channel id, high data bits and idle counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= PS_HDR;
      chan_q  <= CH_DSKY_VERB;
      hi_q    <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      hi_q    <= hi_d;
      idle_q  <= idle_d;
    end
  end

  // Next-state: a received byte always takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    hi_d    = hi_q;
    idle_d  = idle_q;
    load_en = 1'b0;
    err_d   = 1'b0;
    if (byte_err) begin
      err_d   = 1'b1;
      state_d = PS_HDR;
      idle_d  = '0;
    end else if (byte_valid) begin
      idle_d = '0;
      case (state_q)
        PS_HDR: begin
          if (is_header(byte_data)) begin
            chan_d  = chan_e'(byte_data[2:0]);
            state_d = PS_HI;
          end else begin
            err_d = 1'b1;
          end
        end
        PS_HI: begin
          if (byte_data[7]) begin
            err_d   = 1'b1;
            state_d = PS_HDR;
          end else begin
            hi_d    = byte_data[6:0];
            state_d = PS_LO;
          end
        end
        PS_LO: begin
          load_en = 1'b1;
          state_d = PS_HDR;
        end
        default: begin
          err_d   = 1'b1;
          state_d = PS_HDR;
        end
      endcase
    end else if (state_q == PS_HDR) begin
      idle_d = '0;
    end else if (timeout_hit) begin
      err_d   = 1'b1;
      state_d = PS_HDR;
      idle_d  = '0;
    end else begin
      idle_d = idle_q + 1'b1;
    end
  end

  // Channel registers and the registered update / error strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      update_valid <= 1'b0;
      update_chan  <= '0;
      frame_err    <= 1'b0;
      for (int i = 0; i < NUM_CHAN; i++) chan_reg[i] <= '0;
    end else begin
      update_valid <= load_en;
      frame_err    <= err_d;
      if (load_en) update_chan <= chan_q;
      for (int i = 0; i < NUM_CHAN; i++) begin
        if (load_en && (chan_q == 3'(i))) chan_reg[i] <= {hi_q, byte_data};
      end
    end
  end

endmodule

// File: tb/tb_io_serial_rx.sv
// Bench for io_serial_rx: vector table, hand-written corner sequences and
// randomized frames checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_io_serial_rx;

  localparam int CPB = 8;
  localparam int TMO = 100;
  localparam int EW  = 19;
  localparam logic [EW-1:0] EV_ERR = {1'b1, 18'd0};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx_serial = 1'b1;
  logic [14:0] dsky_verb, dsky_noun, axi_g, axi_ra, axi_rb, axi_atx;
  logic        update_valid;
  logic [2:0]  update_chan;
  logic        frame_err;

  io_serial_rx #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_serial   (rx_serial),
    .dsky_verb   (dsky_verb),
    .dsky_noun   (dsky_noun),
    .axi_g       (axi_g),
    .axi_ra      (axi_ra),
    .axi_rb      (axi_rb),
    .axi_atx     (axi_atx),
    .update_valid(update_valid),
    .update_chan (update_chan),
    .frame_err   (frame_err)
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  logic [14:0] dut_ch [6];
  assign dut_ch[0] = dsky_verb;
  assign dut_ch[1] = dsky_noun;
  assign dut_ch[2] = axi_g;
  assign dut_ch[3] = axi_ra;
  assign dut_ch[4] = axi_rb;
  assign dut_ch[5] = axi_atx;

  // Scoreboard state
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];
  logic [14:0]   model_ch [6];
  int checks = 0;
  int errors = 0;

  // Monitor: records every update / error strobe, checks their exclusivity.
  always @(negedge clock) begin
    if (!reset && (update_valid || frame_err)) begin
      checks++;
      if (update_valid && frame_err) begin
        errors++;
        $display("FAIL strobe_excl: update_valid=1 frame_err=1, required at most one");
      end
      if (frame_err) obs_q.push_back(EV_ERR);
      else if (update_chan < 3'd6) obs_q.push_back({1'b0, update_chan, dut_ch[update_chan]});
      else obs_q.push_back({1'b0, update_chan, 15'd0});
    end
  end

  // Reference model: frame-level rules
  function automatic logic hdr_ok(input logic [7:0] b);
    return (b[7:3] == 5'b10100) && (b[2:0] <= 3'd5);
  endfunction

  task automatic model_upd(input int ch, input logic [14:0] v);
    exp_q.push_back({1'b0, 3'(ch), v});
    model_ch[ch] = v;
  endtask

  task automatic model_err();
    exp_q.push_back(EV_ERR);
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_serial = bits[i];
      idle(CPB);
    end
    rx_serial = 1'b1;
  endtask

  // Compare observed strobes and channel values against the model.
  task automatic drain_check(input string name);
    logic [EW-1:0] e, o;
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s event_count: got %0d required %0d", name, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s event: got err=%0d ch=%0d val=%h required err=%0d ch=%0d val=%h",
                 name, o[18], o[17:15], o[14:0], e[18], e[17:15], e[14:0]);
      end
    end
    exp_q.delete();
    obs_q.delete();
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (dut_ch[c] !== model_ch[c]) begin
        errors++;
        $display("FAIL %s chan%0d: got %h required %h", name, c, dut_ch[c], model_ch[c]);
      end
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (dut_ch[c] !== 15'd0) begin
        errors++;
        $display("FAIL %s chan%0d: got %h required 0", name, c, dut_ch[c]);
      end
    end
    checks++;
    if ({update_valid, update_chan, frame_err} !== 5'd0) begin
      errors++;
      $display("FAIL %s strobes: got uv=%0d uc=%0d fe=%0d required all 0",
               name, update_valid, update_chan, frame_err);
    end
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    int          kind;   // 0 none, 1 update, 2 frame error
    int          ch;
    logic [14:0] val;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int seen;
    int kind, ch;
    logic [14:0] v;
    logic [7:0] b;

    for (int c = 0; c < 6; c++) model_ch[c] = '0;

    tbl.push_back('{8'hA0, 1'b1, 0, 0, 15'h0000});
    tbl.push_back('{8'h00, 1'b1, 0, 0, 15'h0000});
    tbl.push_back('{8'h37, 1'b1, 1, 0, 15'h0037});
    tbl.push_back('{8'hA5, 1'b1, 0, 0, 15'h0000});
    tbl.push_back('{8'h55, 1'b1, 0, 0, 15'h0000});
    tbl.push_back('{8'hBC, 1'b1, 1, 5, 15'h55BC});
    tbl.push_back('{8'hA1, 1'b1, 0, 0, 15'h0000});
    tbl.push_back('{8'h00, 1'b1, 0, 0, 15'h0000});
    tbl.push_back('{8'h05, 1'b1, 1, 1, 15'h0005});
    tbl.push_back('{8'hA6, 1'b1, 2, 0, 15'h0000});
    tbl.push_back('{8'hA2, 1'b1, 0, 0, 15'h0000});
    tbl.push_back('{8'h81, 1'b1, 2, 0, 15'h0000});
    tbl.push_back('{8'hA2, 1'b1, 0, 0, 15'h0000});
    tbl.push_back('{8'h01, 1'b1, 0, 0, 15'h0000});
    tbl.push_back('{8'h23, 1'b1, 1, 2, 15'h0123});
    tbl.push_back('{8'hA3, 1'b1, 0, 0, 15'h0000});
    tbl.push_back('{8'h11, 1'b0, 2, 0, 15'h0000});

    // Reset
    idle(3);
    check_all_zero("reset_init");
    reset = 1'b0;
    idle(4);

    // Vector table
    for (int i = 0; i < tbl.size(); i++) begin
      send_byte(tbl[i].data, tbl[i].stop);
      idle(4);
      if (tbl[i].kind == 1) model_upd(tbl[i].ch, tbl[i].val);
      else if (tbl[i].kind == 2) model_err();
      drain_check($sformatf("vec%0d", i));
    end

    // Short low glitch on an idle line: no byte, no error
    idle(2 * CPB);
    rx_serial = 1'b0;
    idle(2);
    rx_serial = 1'b1;
    idle(3 * CPB);
    drain_check("glitch");

    send_byte(8'hA3, 1'b1);
    send_byte(8'h07, 1'b1);
    send_byte(8'h89, 1'b1);
    idle(4);
    model_upd(3, 15'h0789);
    drain_check("after_glitch");

    // Inter-byte timeout aborts the frame after TMO idle clocks
    send_byte(8'hA4, 1'b1);
    send_byte(8'h04, 1'b1);
    seen = -1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (frame_err && seen < 0) seen = i;
    end
    checks++;
    if (seen < 90 || seen > 110) begin
      errors++;
      $display("FAIL timeout_delay: got %0d clocks required 90..110", seen);
    end
    model_err();
    drain_check("timeout");
    send_byte(8'h56, 1'b1);
    idle(4);
    model_err();
    drain_check("after_timeout");

    // Randomized frames against the frame-level model
    for (int u = 0; u < 40; u++) begin
      kind = $urandom_range(0, 9);
      if (kind < 6) begin
        ch = $urandom_range(0, 5);
        v  = 15'($urandom());
        send_byte({5'b10100, 3'(ch)}, 1'b1);
        idle($urandom_range(0, 6));
        send_byte({1'b0, v[14:8]}, 1'b1);
        idle($urandom_range(0, 6));
        send_byte(v[7:0], 1'b1);
        model_upd(ch, v);
      end else if (kind < 8) begin
        do b = 8'($urandom()); while (hdr_ok(b));
        send_byte(b, 1'b1);
        model_err();
      end else if (kind == 8) begin
        send_byte({5'b10100, 3'($urandom_range(0, 5))}, 1'b1);
        idle($urandom_range(0, 6));
        send_byte({1'b1, 7'($urandom())}, 1'b1);
        model_err();
      end else begin
        send_byte(8'($urandom()), 1'b0);
        model_err();
      end
      idle($urandom_range(4, 40));
      drain_check($sformatf("rand%0d", u));
    end

    // Reset between HI and LO bytes discards the frame
    send_byte(8'hA4, 1'b1);
    send_byte(8'h04, 1'b1);
    idle(4);
    reset = 1'b1;
    #1;
    check_all_zero("reset_mid");
    for (int c = 0; c < 6; c++) model_ch[c] = '0;
    exp_q.delete();
    obs_q.delete();
    idle(3);
    reset = 1'b0;
    idle(4);
    send_byte(8'h56, 1'b1);
    idle(4);
    model_err();
    drain_check("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
